// File: rtl/switch_debounce_sync_if.sv
// Switch conditioning bus: raw switch levels in, debounced levels, change strobe and sample tick out.
// The master side drives in_raw; the slave side is the debouncer.
interface switch_debounce_sync_if #(
  parameter int WIDTH = 9
);
  logic [WIDTH-1:0] in_raw;
  logic [WIDTH-1:0] in_clean;
  logic             changed;
  logic             tick;

  modport master (
    output in_raw,
    input  in_clean,
    input  changed,
    input  tick
  );

  modport slave (
    input  in_raw,
    output in_clean,
    output changed,
    output tick
  );
endinterface

// File: rtl/switch_debounce_sync.sv
// Two-flop synchroniser plus per-bit tick-qualified debouncer for the slide switches.
// A bit changes only after it has differed from its clean level for STABLE_TICKS sample ticks in a row.
module switch_debounce_sync #(
  parameter int WIDTH        = 9,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  switch_debounce_sync_if.slave sw
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] clean_q;
  logic [WIDTH-1:0] clean_d;
  logic [WIDTH-1:0] accept;
  logic [PW-1:0]    pre_q;
  logic             tick_q;
  logic             changed_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw.in_raw;
      s2 <= s1;
    end
  end

  // tick is registered off the wrap so it rises on the TICK_DIV-th edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pre_q == PRE_LAST);
      if (pre_q == PRE_LAST) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  always_comb begin
    clean_d = clean_q;
    accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          clean_d[i] = s2[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q   <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q   <= clean_d;
      changed_q <= |accept;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw.in_clean = clean_q;
  assign sw.changed  = changed_q;
  assign sw.tick     = tick_q;
endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed bench for switch_debounce_sync with TICK_DIV=4, STABLE_TICKS=3.
// Inputs change on falling edges; outputs are sampled 1 time unit after rising edges or on falling edges.
module tb_switch_debounce_sync;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   pulses;

  switch_debounce_sync_if #(.WIDTH(9)) sw ();

  switch_debounce_sync #(
    .WIDTH       (9),
    .TICK_DIV    (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pulses = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sw.changed === 1'b1) pulses++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for in_clean to leave 'old'; lat is the rising-edge count, -1 on timeout.
  task automatic wait_change(input logic [8:0] old, input int budget,
                             output int lat, output logic chg_at);
    lat    = -1;
    chg_at = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (sw.in_clean !== old) begin
        lat    = i;
        chg_at = sw.changed;
        break;
      end
    end
  endtask

  int   lat;
  int   lat2;
  int   p0;
  int   nticks;
  logic chg;
  logic bad;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    sw.in_raw = 9'h1FF;

    // 1: reset holds everything low even with all switches high
    repeat (3) @(negedge clk);
    chk("t1_rst_clean", 32'(sw.in_clean), 32'h000);
    chk("t1_rst_changed", 32'(sw.changed), 32'h0);
    chk("t1_rst_tick", 32'(sw.tick), 32'h0);
    sw.in_raw = 9'h000;
    rst_n     = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t1_tick_cyc%0d", i), 32'(sw.tick), ((i % 4) == 0) ? 32'h1 : 32'h0);
    end

    // 2: clean step
    @(negedge clk);
    p0 = pulses;
    sw.in_raw = 9'h1A5;
    wait_change(9'h000, 20, lat, chg);
    chk($sformatf("t2_latency_%0d_in_11_14", lat), 32'(lat >= 11 && lat <= 14), 32'h1);
    chk("t2_clean", 32'(sw.in_clean), 32'h1A5);
    chk("t2_changed_at_update", 32'(chg), 32'h1);
    @(posedge clk);
    #1;
    chk("t2_changed_one_cycle", 32'(sw.changed), 32'h0);
    chk("t2_pulse_count", 32'(pulses - p0), 32'd1);

    // 3: return to zero, then bounce bit0 every 3 cycles
    @(negedge clk);
    sw.in_raw = 9'h000;
    wait_change(9'h1A5, 20, lat, chg);
    chk("t3_back_to_zero", 32'(sw.in_clean), 32'h000);
    @(negedge clk);
    p0  = pulses;
    bad = 1'b0;
    for (int k = 0; k < 14; k++) begin
      sw.in_raw = (k % 2 == 0) ? 9'h001 : 9'h000;
      repeat (3) begin
        @(negedge clk);
        if (sw.in_clean !== 9'h000) bad = 1'b1;
      end
    end
    chk("t3_stable_during_bounce", 32'(bad), 32'h0);
    chk("t3_no_pulse_during_bounce", 32'(pulses - p0), 32'd0);
    sw.in_raw = 9'h001;
    wait_change(9'h000, 20, lat, chg);
    chk($sformatf("t3_latency_%0d_in_11_14", lat), 32'(lat >= 11 && lat <= 14), 32'h1);
    chk("t3_clean", 32'(sw.in_clean), 32'h001);
    chk("t3_changed_at_update", 32'(chg), 32'h1);
    repeat (6) @(negedge clk);
    chk("t3_single_pulse", 32'(pulses - p0), 32'd1);

    // 4: glitch too short to qualify
    p0  = pulses;
    bad = 1'b0;
    sw.in_raw = 9'h101;
    repeat (8) @(negedge clk);
    sw.in_raw = 9'h001;
    repeat (24) begin
      @(negedge clk);
      if (sw.in_clean !== 9'h001) bad = 1'b1;
    end
    chk("t4_clean_unchanged", 32'(bad), 32'h0);
    chk("t4_no_pulse", 32'(pulses - p0), 32'd0);

    // 5: bits 1,2 together, bit 3 four cycles later
    p0 = pulses;
    sw.in_raw = 9'h007;
    repeat (4) @(negedge clk);
    sw.in_raw = 9'h00F;
    wait_change(9'h001, 20, lat, chg);
    chk("t5_first_update", 32'(sw.in_clean), 32'h007);
    chk("t5_first_changed", 32'(chg), 32'h1);
    wait_change(9'h007, 20, lat2, chg);
    chk("t5_second_update", 32'(sw.in_clean), 32'h00F);
    chk("t5_second_changed", 32'(chg), 32'h1);
    chk($sformatf("t5_pulse_gap_%0d_ge_4", lat2), 32'(lat2 >= 4 && lat2 <= 8), 32'h1);
    repeat (3) @(negedge clk);
    chk("t5_two_pulses", 32'(pulses - p0), 32'd2);

    // 6: reset two ticks into qualifying 0FF
    sw.in_raw = 9'h0FF;
    repeat (2) @(negedge clk);
    nticks = 0;
    for (int i = 0; i < 20 && nticks < 2; i++) begin
      @(negedge clk);
      if (sw.tick === 1'b1) nticks++;
    end
    chk("t6_two_ticks_seen", 32'(nticks), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_async_clean", 32'(sw.in_clean), 32'h000);
    chk("t6_async_changed", 32'(sw.changed), 32'h0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (sw.in_clean !== 9'h000) bad = 1'b1;
    end
    chk("t6_held_in_reset", 32'(bad), 32'h0);
    rst_n = 1'b1;
    // release on a falling edge: s2 valid after edge 2, ticks consumed at edges 5, 9, 13
    wait_change(9'h000, 24, lat, chg);
    chk($sformatf("t6_latency_%0d_in_13_17", lat), 32'(lat >= 13 && lat <= 17), 32'h1);
    chk("t6_clean", 32'(sw.in_clean), 32'h0FF);
    chk("t6_changed_at_update", 32'(chg), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
